// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Brief    : Elastic pipeline-stage register with valid/ready handshake,
//            two-entry skid buffer, flush, bubble insertion and stall counter.
// Revision : 1.0
// ============================================================================
module pipe_stage_reg #(
  parameter int CTRL_W = 12,
  parameter int DATA_W = 176,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              main_valid_q, main_valid_d;
  logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;

  logic accept;
  logic pop;

  // The skid entry is only ever occupied behind a valid main entry, so
  // ready depends on the skid valid bit alone.
  assign in_ready  = ~skid_valid_q;
  assign accept    = in_valid & in_ready & ~flush;
  assign pop       = main_valid_q & out_ready;

  assign out_valid = main_valid_q;
  assign out_ctrl  = main_valid_q ? main_ctrl_q : '0;
  assign out_data  = main_data_q;
  assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    main_valid_d = main_valid_q;
    main_ctrl_d  = main_ctrl_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_data_d  = skid_data_q;

    if (flush) begin
      // Squash only the valid bits; data registers keep their contents.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q) begin
      if (accept) begin
        main_valid_d = 1'b1;
        main_ctrl_d  = in_ctrl;
        main_data_d  = in_data;
      end
    end else if (!skid_valid_q) begin
      if (accept && pop) begin
        main_ctrl_d  = in_ctrl;
        main_data_d  = in_data;
      end else if (accept) begin
        skid_valid_d = 1'b1;
        skid_ctrl_d  = in_ctrl;
        skid_data_d  = in_data;
      end else if (pop) begin
        main_valid_d = 1'b0;
      end
    end else if (pop) begin
      main_ctrl_d  = skid_ctrl_q;
      main_data_d  = skid_data_q;
      skid_valid_d = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      main_ctrl_q  <= '0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_data_q  <= '0;
      stall_cnt_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_ctrl_q  <= main_ctrl_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_data_q  <= skid_data_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised elastic pipeline-stage register for the processor datapath, replacing fixed per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one reusable block. It carries a control bundle and a data bundle between adjacent stages. It adds a valid/ready handshake, a two-entry skid buffer so that ready carries no combinational path from downstream, synchronous flush for branch/jump squash, and automatic bubble insertion (control zeroed) whenever no valid instruction is presented. A saturating stall counter supports performance debug.

## Interface
- CTRL_W, 12, width of control bundle (regDest, regWrite, ALUSrc, MemRead, MemWrite, MemToReg, Branch, Jump, ALUControl[3:0] at ID/EX); zeroed on bubble/flush
- DATA_W, 176, width of data bundle (IR, PC, A, B, regDestAddress, branch and jump targets at ID/EX); never zeroed except by reset
- CNT_W, 16, width of stall counter
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- in_valid  in  1  upstream presents an instruction
- in_ready  out  1  block can accept this cycle
- in_ctrl  in  CTRL_W  upstream control bundle
- in_data  in  DATA_W  upstream data bundle
- flush  in  1  synchronous squash of all held entries and of the current input
- out_valid  out  1  valid instruction at output
- out_ready  in  1  downstream consumes this cycle
- out_ctrl  out  CTRL_W  control to next stage; all-zero when out_valid=0
- out_data  out  DATA_W  data to next stage
- occupancy  out  2  held entries, 0..2
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

## Operation
- Storage: main entry (drives outputs) and skid entry, each with ctrl, data and a valid bit.
- accept = in_valid & in_ready & !flush; pop = out_valid & out_ready.
- in_ready = (occupancy != 2); decoded from registered state only, with no combinational path from out_ready or flush.
- out_valid = main valid; out_ctrl = main valid ? main ctrl : 0; out_data = main data (holds last value when invalid).
- States (occupancy):
  - EMPTY(0): accept -> ONE, main <= input.
  - ONE(1): accept & pop -> ONE, main <= input. accept & !pop -> FULL, skid <= input. !accept & pop -> EMPTY. Otherwise hold.
  - FULL(2): pop -> ONE, main <= skid. Otherwise hold. No accept is possible because in_ready=0.
- flush: next state EMPTY regardless of occupancy, in_valid and out_ready. Both valid bits clear and the input is discarded. Data registers keep their values. flush has priority over every other transition.
- stall_cnt: +1 on every cycle with out_valid & !out_ready. Holds at 2^CNT_W-1. Cleared only by reset; flush does not clear it.
- Data is never reordered. Output order equals accept order.

## Timing
- Reset values: occupancy=0, out_valid=0, out_ctrl=0, out_data=0, in_ready=1, stall_cnt=0, skid contents 0. These apply asynchronously on reset assertion and hold while reset is high.
- Reset deassertion: first accept occurs on the first rising edge with reset low.
- Latency: an input accepted at edge N appears on the output after edge N (1 cycle) when the block was EMPTY or ONE-with-pop.
- Throughput: 1 per cycle sustained with out_ready=1.
- Backpressure: after out_ready drops, one more input is absorbed into skid, then in_ready=0 from the next cycle.
- Flush at edge N: out_valid=0, out_ctrl=0, in_ready=1 after edge N. An item popped in the same cycle counts as delivered downstream.
- Reset mid-transfer: all held entries are lost. No output is produced from pre-reset state.

## Test plan
- Reset: assert reset asynchronously mid-cycle while FULL -> outputs immediately reach out_valid=0, out_ctrl=0, occupancy=0, in_ready=1, stall_cnt=0.
- Streaming (CTRL_W=4, DATA_W=32): in_valid=1, out_ready=1, data 0x10..0x17 -> out_data 0x10..0x17 on consecutive cycles, each one cycle after input; occupancy stays 1; stall_cnt=0.
- Backpressure: stream 0xA1, 0xA2, 0xA3 with out_ready=0 from the second cycle -> occupancy 1 then 2; in_ready=0; 0xA3 held upstream. Raise out_ready -> output 0xA1, 0xA2, 0xA3 in order; stall_cnt equals the number of stalled cycles.
- Flush while FULL with in_valid=1 (ctrl 0xF) -> next cycle occupancy=0, out_valid=0, out_ctrl=0x0, in_ready=1; the flushed input never appears.
- Bubble: in_valid=0 for 3 cycles after item ctrl 0x9 is popped -> out_ctrl=0x0 for those cycles; out_data still equals the last item.
- Saturation (CNT_W=4): hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt stops at 0xF; a following flush leaves it at 0xF.
